// File: rtl/imem_arb.sv
// Arbitrates a fetch port and a load/store port onto one memory port with at most
// one outstanding access; fetch is forced through after STARVE_MAX consecutive losses.
module imem_arb #(
   parameter int XLEN       = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   // fetch port
   input  logic                if_req_i,
   input  logic [XLEN-1:0]     if_adr_i,
   input  logic                if_flush_i,
   output logic                if_gnt_o,
   output logic                if_rvalid_o,
   output logic [31:0]         if_rdata_o,
   // load/store port
   input  logic                ls_req_i,
   input  logic                ls_we_i,
   input  logic [XLEN-1:0]     ls_adr_i,
   input  logic [XLEN-1:0]     ls_wdata_i,
   input  logic [XLEN/8-1:0]   ls_be_i,
   output logic                ls_gnt_o,
   output logic                ls_rvalid_o,
   output logic [XLEN-1:0]     ls_rdata_o,
   // memory port
   output logic                mem_req_o,
   output logic                mem_we_o,
   output logic [XLEN-1:0]     mem_adr_o,
   output logic [XLEN-1:0]     mem_wdata_o,
   output logic [XLEN/8-1:0]   mem_be_o,
   input  logic                mem_gnt_i,
   input  logic                mem_rvalid_i,
   input  logic [XLEN-1:0]     mem_rdata_i
);

   localparam int CW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

   typedef enum logic [2:0] {IDLE, REQ, WAIT_IF, WAIT_LS, DROP} state_t;

   state_t          state_q, state_d;
   logic            sel_ls_q, sel_ls_d;
   logic [CW-1:0]   starve_q, starve_d;
   logic            sel_ls;
   logic            req_sel;
   logic            grant;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         sel_ls_q <= 1'b0;
         starve_q <= '0;
      end else begin
         state_q  <= state_d;
         sel_ls_q <= sel_ls_d;
         starve_q <= starve_d;
      end
   end

   // Outputs are held at zero while reset_n is low, even though the arbitration
   // path from the request inputs is otherwise purely combinational.
   always_comb begin
      state_d     = state_q;
      sel_ls_d    = 1'b0;
      starve_d    = starve_q;
      sel_ls      = 1'b0;
      req_sel     = 1'b0;
      grant       = 1'b0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_adr_o   = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      if_gnt_o    = 1'b0;
      ls_gnt_o    = 1'b0;
      if_rvalid_o = 1'b0;
      if_rdata_o  = '0;
      ls_rvalid_o = 1'b0;
      ls_rdata_o  = '0;
      if (reset_n) begin
         case (state_q)
            IDLE, REQ: begin
               if (state_q == REQ) sel_ls = sel_ls_q;
               else                sel_ls = ls_req_i && !(starve_q == SMAX && if_req_i);
               req_sel   = sel_ls ? ls_req_i : if_req_i;
               grant     = req_sel & mem_gnt_i;
               mem_req_o = req_sel;
               if (req_sel) begin
                  if (sel_ls) begin
                     mem_we_o    = ls_we_i;
                     mem_adr_o   = ls_adr_i;
                     mem_wdata_o = ls_wdata_i;
                     mem_be_o    = ls_be_i;
                  end else begin
                     mem_adr_o   = if_adr_i;
                     mem_be_o    = '1;
                  end
               end
               if_gnt_o = grant & ~sel_ls;
               ls_gnt_o = grant & sel_ls;
               // A flushed fetch that is not granted is withdrawn; one granted in
               // the same cycle still owns the memory response, so it is dropped later.
               if (grant) begin
                  if (sel_ls)          state_d = WAIT_LS;
                  else if (if_flush_i) state_d = DROP;
                  else                 state_d = WAIT_IF;
               end else if (req_sel && !(!sel_ls && if_flush_i)) begin
                  state_d  = REQ;
                  sel_ls_d = sel_ls;
               end else begin
                  state_d  = IDLE;
               end
               if (grant && !sel_ls) begin
                  starve_d = '0;
               end else if (grant && sel_ls && if_req_i) begin
                  if (starve_q != SMAX) starve_d = starve_q + 1'b1;
               end else if (state_q == IDLE && !if_req_i) begin
                  starve_d = '0;
               end
            end
            WAIT_IF: begin
               if (mem_rvalid_i) begin
                  if_rvalid_o = ~if_flush_i;
                  if_rdata_o  = if_flush_i ? '0 : mem_rdata_i[31:0];
                  state_d     = IDLE;
               end else if (if_flush_i) begin
                  state_d     = DROP;
               end
            end
            WAIT_LS: begin
               if (mem_rvalid_i) begin
                  ls_rvalid_o = 1'b1;
                  ls_rdata_o  = mem_rdata_i;
                  state_d     = IDLE;
               end
            end
            DROP: begin
               if (mem_rvalid_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_arb.sv
// Randomized and directed checks of imem_arb against a transaction-level reference model.
module tb_imem_arb;

   localparam int XLEN = 32;
   localparam int SMAX = 4;
   localparam int BW   = XLEN / 8;

   logic              clk = 1'b0;
   logic              reset_n;
   logic              if_req_i, if_flush_i;
   logic [XLEN-1:0]   if_adr_i;
   logic              if_gnt_o, if_rvalid_o;
   logic [31:0]       if_rdata_o;
   logic              ls_req_i, ls_we_i;
   logic [XLEN-1:0]   ls_adr_i, ls_wdata_i;
   logic [BW-1:0]     ls_be_i;
   logic              ls_gnt_o, ls_rvalid_o;
   logic [XLEN-1:0]   ls_rdata_o;
   logic              mem_req_o, mem_we_o;
   logic [XLEN-1:0]   mem_adr_o, mem_wdata_o;
   logic [BW-1:0]     mem_be_o;
   logic              mem_gnt_i, mem_rvalid_i;
   logic [XLEN-1:0]   mem_rdata_i;

   always #5 clk = ~clk;

   imem_arb #(.XLEN(XLEN), .STARVE_MAX(SMAX)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_flush_i(if_flush_i),
      .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
      .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_adr_i(ls_adr_i),
      .ls_wdata_i(ls_wdata_i), .ls_be_i(ls_be_i),
      .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_adr_o(mem_adr_o),
      .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
      .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
   );

   int unsigned total = 0;
   int unsigned bad   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference model: pend = requester waiting for grant (0 none, 1 fetch, 2 lsu),
   // outst = who owns the in-flight access (0 none, 1 fetch, 2 lsu, 3 discarded fetch).
   int m_pend, m_outst, m_starve;
   int n_pend, n_outst, n_starve;
   logic            e_mem_req, e_mem_we, e_if_gnt, e_ls_gnt, e_if_rv, e_ls_rv;
   logic [XLEN-1:0] e_mem_adr, e_mem_wdata, e_ls_rdata;
   logic [BW-1:0]   e_mem_be;
   logic [31:0]     e_if_rdata;

   int  glog[$];
   int  mem_busy, mem_dly, dly_max;
   bit  auto_mem, gnt_always, spurious;

   task automatic model_eval();
      int who;
      bit r;
      e_mem_req = 0; e_mem_we = 0; e_mem_adr = '0; e_mem_wdata = '0; e_mem_be = '0;
      e_if_gnt = 0; e_ls_gnt = 0; e_if_rv = 0; e_ls_rv = 0;
      e_if_rdata = '0; e_ls_rdata = '0;
      n_pend = m_pend; n_outst = m_outst; n_starve = m_starve;
      if (!reset_n) begin
         n_pend = 0; n_outst = 0; n_starve = 0;
      end else if (m_outst == 0) begin
         if (m_pend != 0)                                   who = m_pend;
         else if (ls_req_i && !(m_starve == SMAX && if_req_i)) who = 2;
         else if (if_req_i)                                 who = 1;
         else                                               who = 0;
         r = (who == 1) ? if_req_i : (who == 2) ? ls_req_i : 1'b0;
         if (r) begin
            e_mem_req = 1;
            if (who == 2) begin
               e_mem_we = ls_we_i; e_mem_adr = ls_adr_i; e_mem_wdata = ls_wdata_i;
               e_mem_be = ls_be_i; e_ls_gnt = mem_gnt_i;
            end else begin
               e_mem_adr = if_adr_i; e_mem_be = {BW{1'b1}}; e_if_gnt = mem_gnt_i;
            end
         end
         if (r && mem_gnt_i) begin
            n_pend  = 0;
            n_outst = (who == 2) ? 2 : (if_flush_i ? 3 : 1);
         end else if (r) begin
            n_pend = (who == 1 && if_flush_i) ? 0 : who;
         end else begin
            n_pend = 0;
         end
         if (e_if_gnt)                        n_starve = 0;
         else if (e_ls_gnt && if_req_i)       n_starve = (m_starve < SMAX) ? m_starve + 1 : SMAX;
         else if (m_pend == 0 && !if_req_i)   n_starve = 0;
      end else if (m_outst == 1) begin
         if (mem_rvalid_i) begin
            e_if_rv = !if_flush_i;
            if (!if_flush_i) e_if_rdata = mem_rdata_i[31:0];
            n_outst = 0;
         end else if (if_flush_i) begin
            n_outst = 3;
         end
      end else if (m_outst == 2) begin
         if (mem_rvalid_i) begin
            e_ls_rv = 1; e_ls_rdata = mem_rdata_i; n_outst = 0;
         end
      end else begin
         if (mem_rvalid_i) n_outst = 0;
      end
   endtask

   task automatic drive_mem();
      if (!auto_mem) return;
      mem_rdata_i  = $urandom;
      mem_gnt_i    = gnt_always ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (mem_busy != 0) mem_rvalid_i = (mem_dly == 0);
      else               mem_rvalid_i = spurious && ($urandom_range(0, 7) == 0);
   endtask

   // Caller is at a negedge with inputs applied; checks, then advances one clock.
   task automatic step();
      #1;
      model_eval();
      check("mem_req", mem_req_o, e_mem_req);
      check("if_gnt", if_gnt_o, e_if_gnt);
      check("ls_gnt", ls_gnt_o, e_ls_gnt);
      check("if_rvalid", if_rvalid_o, e_if_rv);
      check("ls_rvalid", ls_rvalid_o, e_ls_rv);
      if (!reset_n || e_mem_req) begin
         check("mem_we", mem_we_o, e_mem_we);
         check("mem_adr", mem_adr_o, e_mem_adr);
         check("mem_wdata", mem_wdata_o, e_mem_wdata);
         check("mem_be", mem_be_o, e_mem_be);
      end
      if (!reset_n || e_if_rv) check("if_rdata", if_rdata_o, e_if_rdata);
      if (!reset_n || e_ls_rv) check("ls_rdata", ls_rdata_o, e_ls_rdata);
      if (if_gnt_o) glog.push_back(1);
      if (ls_gnt_o) glog.push_back(2);
      @(posedge clk);
      m_pend = n_pend; m_outst = n_outst; m_starve = n_starve;
      if (!reset_n) mem_busy = 0;
      else if (mem_busy != 0) begin
         if (mem_dly == 0) mem_busy = 0;
         else              mem_dly--;
      end
      if (reset_n && (e_if_gnt || e_ls_gnt)) begin
         mem_busy = 1;
         mem_dly  = $urandom_range(0, dly_max);
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      if_req_i = 0; if_flush_i = 0; if_adr_i = '0;
      ls_req_i = 0; ls_we_i = 0; ls_adr_i = '0; ls_wdata_i = '0; ls_be_i = '0;
      mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
   endtask

   task automatic do_reset();
      reset_n = 0;
      idle_inputs();
      step();
      step();
      reset_n = 1;
      mem_busy = 0;
      step();
   endtask

   initial begin
      auto_mem = 0; gnt_always = 0; spurious = 0; dly_max = 2;
      m_pend = 0; m_outst = 0; m_starve = 0; mem_busy = 0; mem_dly = 0;
      idle_inputs();
      reset_n = 0;
      @(negedge clk);
      check("reset_mem_req", mem_req_o, 1'b0);
      do_reset();

      // single fetch: same-cycle grant, response two cycles later
      if_req_i = 1; if_adr_i = 32'h80; mem_gnt_i = 1;
      #1 check("t25_gnt", if_gnt_o, 1'b1);
      check("t25_adr", mem_adr_o, 32'h80);
      step();
      if_req_i = 0; mem_gnt_i = 0;
      #1 check("t25_gnt_once", if_gnt_o, 1'b0);
      step();
      mem_rvalid_i = 1; mem_rdata_i = 32'h00000013;
      #1 check("t25_rvalid", if_rvalid_o, 1'b1);
      check("t25_rdata", if_rdata_o, 32'h00000013);
      step();
      idle_inputs();
      step();

      // starvation: both request forever, memory always grants, response next cycle
      do_reset();
      auto_mem = 1; gnt_always = 1; dly_max = 0; spurious = 0;
      glog.delete();
      if_req_i = 1; ls_req_i = 1;
      for (int c = 0; c < 20; c++) begin
         if_adr_i = $urandom; ls_adr_i = $urandom; ls_wdata_i = $urandom;
         ls_we_i = $urandom_range(0, 1); ls_be_i = BW'($urandom);
         drive_mem();
         step();
      end
      check("t26_count", glog.size(), 10);
      for (int i = 0; i < glog.size() && i < 10; i++)
         check($sformatf("t26_order%0d", i), glog[i], ((i % 5) == 4) ? 1 : 2);
      auto_mem = 0;
      idle_inputs();
      do_reset();

      // LSU write held pending for 3 cycles while fetch toggles
      ls_req_i = 1; ls_we_i = 1; ls_adr_i = 32'h100; ls_wdata_i = 32'hDEADBEEF; ls_be_i = 4'h3;
      for (int c = 0; c < 4; c++) begin
         if_req_i = (c % 2 == 0);
         mem_gnt_i = (c == 3);
         #1;
         check("t27_req", mem_req_o, 1'b1);
         check("t27_adr", mem_adr_o, 32'h100);
         check("t27_we", mem_we_o, 1'b1);
         check("t27_wdata", mem_wdata_o, 32'hDEADBEEF);
         check("t27_be", mem_be_o, 4'h3);
         check("t27_if_gnt", if_gnt_o, 1'b0);
         check("t27_ls_gnt", ls_gnt_o, (c == 3));
         step();
      end
      idle_inputs();
      mem_rvalid_i = 1;
      #1 check("t27_ls_rvalid", ls_rvalid_o, 1'b1);
      step();
      idle_inputs();

      // fetch granted then flushed; its response is swallowed
      if_req_i = 1; if_adr_i = 32'h200; mem_gnt_i = 1;
      step();
      idle_inputs(); if_flush_i = 1;
      step();
      idle_inputs(); mem_rvalid_i = 1; mem_rdata_i = 32'h12345678;
      #1 check("t28_if_rvalid", if_rvalid_o, 1'b0);
      step();
      idle_inputs(); ls_req_i = 1; ls_adr_i = 32'h300; mem_gnt_i = 1;
      #1 check("t28_ls_gnt", ls_gnt_o, 1'b1);
      step();
      idle_inputs(); mem_rvalid_i = 1;
      step();
      idle_inputs();

      // reset while a load is outstanding, then a stale response
      ls_req_i = 1; ls_adr_i = 32'h400; mem_gnt_i = 1;
      step();
      reset_n = 0;
      if_req_i = 1; if_adr_i = 32'h500; ls_req_i = 1; ls_we_i = 1; ls_adr_i = 32'h600;
      ls_wdata_i = 32'hCAFEF00D; ls_be_i = '1; mem_gnt_i = 1; mem_rvalid_i = 1;
      mem_rdata_i = 32'hFFFFFFFF;
      #1;
      check("t29_rst_req", mem_req_o, 1'b0);
      check("t29_rst_adr", mem_adr_o, 32'h0);
      check("t29_rst_wdata", mem_wdata_o, 32'h0);
      check("t29_rst_ls_rv", ls_rvalid_o, 1'b0);
      check("t29_rst_ls_rdata", ls_rdata_o, 32'h0);
      check("t29_rst_if_gnt", if_gnt_o, 1'b0);
      step();
      reset_n = 1;
      idle_inputs(); mem_rvalid_i = 1; mem_rdata_i = 32'hA5A5A5A5;
      #1;
      check("t29_stale_ls", ls_rvalid_o, 1'b0);
      check("t29_stale_if", if_rvalid_o, 1'b0);
      step();
      idle_inputs();
      mem_busy = 0;

      // randomized traffic with random latency, spurious responses and resets
      auto_mem = 1; gnt_always = 0; dly_max = 3; spurious = 1;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 299) == 0) begin
            reset_n = 0;
         end else begin
            reset_n = 1;
         end
         if_req_i   = $urandom_range(0, 1);
         if_adr_i   = $urandom;
         if_flush_i = ($urandom_range(0, 7) == 0);
         ls_req_i   = $urandom_range(0, 1);
         ls_we_i    = $urandom_range(0, 1);
         ls_adr_i   = $urandom;
         ls_wdata_i = $urandom;
         ls_be_i    = BW'($urandom);
         drive_mem();
         if (!reset_n) mem_rvalid_i = 0;
         step();
      end
      reset_n = 1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/imem_arb.md
IMEM_ARB -- requirements
Module: imem_arb

Interface
REQ-001 SHALL have parameter XLEN, default 32, address/data width.
REQ-002 SHALL have parameter STARVE_MAX, default 4, consecutive fetch losses before fetch is forced to win.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have fetch ports: if_req_i in 1 request; if_adr_i in XLEN address; if_flush_i in 1 discard in-flight fetch; if_gnt_o out 1 accept; if_rvalid_o out 1 response valid; if_rdata_o out 32 instruction.
REQ-006 SHALL have LSU ports: ls_req_i in 1; ls_we_i in 1 write; ls_adr_i in XLEN; ls_wdata_i in XLEN; ls_be_i in XLEN/8 byte enables; ls_gnt_o out 1; ls_rvalid_o out 1; ls_rdata_o out XLEN.
REQ-007 SHALL have memory ports: mem_req_o out 1; mem_we_o out 1; mem_adr_o out XLEN; mem_wdata_o out XLEN; mem_be_o out XLEN/8; mem_gnt_i in 1; mem_rvalid_i in 1 (one per granted access, at least 1 cycle after grant, writes included); mem_rdata_i in XLEN.

Function
REQ-008 SHALL use an FSM with states IDLE, REQ, WAIT_IF, WAIT_LS, DROP; at most one outstanding memory access.
REQ-009 IDLE/REQ: mem_req_o = selected requester's req; mem_adr/we/wdata/be driven combinationally from the selected requester; fetch access forces mem_we_o=0, mem_be_o all ones.
REQ-010 Arbitration in IDLE: LSU wins if ls_req_i, unless starve_cnt == STARVE_MAX and if_req_i, then fetch wins; fetch wins if only if_req_i.
REQ-011 If mem_req_o=1 and mem_gnt_i=0, SHALL latch the selection and go to REQ; selection SHALL NOT change until granted (no re-arbitration while pending).
REQ-012 if_gnt_o = mem_gnt_i & fetch selected; ls_gnt_o = mem_gnt_i & LSU selected; never both high.
REQ-013 On grant: fetch -> WAIT_IF, LSU -> WAIT_LS; mem_req_o SHALL be 0 in WAIT_IF, WAIT_LS, DROP.
REQ-014 WAIT_IF with mem_rvalid_i: if_rvalid_o=1, if_rdata_o=mem_rdata_i[31:0], same cycle (zero added latency); next state IDLE.
REQ-015 WAIT_LS with mem_rvalid_i: ls_rvalid_o=1, ls_rdata_o=mem_rdata_i; next state IDLE.
REQ-016 if_flush_i in WAIT_IF without mem_rvalid_i -> DROP; in DROP the response SHALL be consumed with if_rvalid_o=0, then IDLE.
REQ-017 if_flush_i coincident with mem_rvalid_i in WAIT_IF: if_rvalid_o=0, next state IDLE.
REQ-018 if_flush_i in IDLE/REQ with fetch selected and no grant: withdraw, selection released, next state IDLE; flush coincident with if_gnt_o: grant stands, next state DROP.
REQ-019 starve_cnt: increment (saturate at STARVE_MAX) when if_req_i=1 and LSU granted; clear when fetch granted or if_req_i=0 in IDLE.
REQ-020 if_rvalid_o/ls_rvalid_o SHALL be 0 outside their WAIT state; mem_rvalid_i in IDLE/REQ SHALL be ignored.
REQ-021 Back-to-back: new arbitration SHALL occur in the IDLE cycle following response; no idle bubble besides that.

Reset
REQ-022 reset_n low SHALL asynchronously force state IDLE, starve_cnt 0, selection register cleared.
REQ-023 During reset all outputs SHALL be 0: mem_req_o, if_gnt_o, ls_gnt_o, if_rvalid_o, ls_rvalid_o, data/address outputs.
REQ-024 Reset mid-transaction SHALL abandon the outstanding access; no rvalid forwarded after reset release until a new grant.

Verification
REQ-025 Fetch only, if_adr_i=0x80, gnt same cycle, rvalid 2 cycles later rdata=0x00000013 -> if_gnt_o 1 cycle, if_rvalid_o=1, if_rdata_o=0x00000013.
REQ-026 Both request continuously, memory always grants, rvalid next cycle -> grant order LSU x4, fetch x1, repeating (STARVE_MAX=4).
REQ-027 LSU write adr=0x100 wdata=0xDEADBEEF be=0x3, gnt delayed 3 cycles while if_req_i toggles -> mem_* stable and LSU-selected all 3 cycles, ls_gnt_o on cycle 4.
REQ-028 Fetch granted, if_flush_i next cycle, rvalid 2 cycles later -> if_rvalid_o stays 0, FSM returns IDLE, following LSU request granted in next cycle.
REQ-029 Reset asserted in WAIT_LS, released, stale mem_rvalid_i pulse -> ls_rvalid_o and if_rvalid_o remain 0; all outputs 0 during reset.
